key_value_counter: RTL and testbench



---
 rtl/key_value_counter.sv | 186 ++++++++++++++++++
 tb/tb_key_value_counter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_value_counter.sv
`default_nettype none
// key_value_counter: debounced inc/dec/load buttons with auto-repeat driving a saturating signed 8-bit value.
// Revision 1.0 - initial release.
module key_value_counter #(
  parameter int DB_CYCLES     = 2000000,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic       btn_load,
  input  logic [7:0] sw,
  output logic [7:0] n,
  output logic       sat
);

  localparam int DBW  = $clog2(DB_CYCLES) + 1;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = $clog2(RMAX) + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_e;

  logic [2:0] btn_raw;
  logic [2:0] step;
  logic [7:0] sw_s1_q;
  logic [7:0] sw_s2_q;
  logic [1:0] vld_q;
  logic [7:0] n_q;
  logic [7:0] n_d;
  logic       sat_q;
  logic       sat_d;

  assign btn_raw = {btn_load, btn_dec, btn_inc};

  // vld_q marks the synchroniser pipes as holding real samples, not reset zeros.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_s1_q <= 8'h00;
      sw_s2_q <= 8'h00;
      vld_q   <= 2'd0;
    end else begin
      sw_s1_q <= sw;
      sw_s2_q <= sw_s1_q;
      if (vld_q != 2'd2) vld_q <= vld_q + 2'd1;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_btn
    logic           s1_q;
    logic           s2_q;
    logic           db_q;
    logic           dbp_q;
    logic           arm_q;
    logic           step_q;
    logic [DBW-1:0] cnt_q;
    logic           rise;

    // A button held through reset stays disarmed until it is seen released.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_q  <= 1'b0;
        s2_q  <= 1'b0;
        db_q  <= 1'b0;
        dbp_q <= 1'b0;
        arm_q <= 1'b0;
        cnt_q <= '0;
      end else begin
        s1_q  <= btn_raw[i];
        s2_q  <= s1_q;
        dbp_q <= db_q;
        if (s2_q == db_q) begin
          cnt_q <= '0;
        end else if (cnt_q == DBW'(DB_CYCLES - 1)) begin
          db_q  <= s2_q;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        if (vld_q == 2'd2 && !s2_q) arm_q <= 1'b1;
      end
    end

    assign rise = db_q & ~dbp_q & arm_q;

    if (i < 2) begin : g_repeat
      rep_state_e       st_q;
      logic [TW-1:0]    tmr_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          st_q   <= ST_IDLE;
          tmr_q  <= '0;
          step_q <= 1'b0;
        end else begin
          step_q <= 1'b0;
          case (st_q)
            ST_IDLE: begin
              if (rise) begin
                step_q <= 1'b1;
                st_q   <= ST_DELAY;
                tmr_q  <= '0;
              end
            end
            ST_DELAY: begin
              if (!db_q) begin
                st_q <= ST_IDLE;
              end else if (tmr_q == TW'(REPEAT_DELAY - 1)) begin
                step_q <= 1'b1;
                st_q   <= ST_REPEAT;
                tmr_q  <= '0;
              end else begin
                tmr_q <= tmr_q + 1'b1;
              end
            end
            ST_REPEAT: begin
              if (!db_q) begin
                st_q <= ST_IDLE;
              end else if (tmr_q == TW'(REPEAT_PERIOD - 1)) begin
                step_q <= 1'b1;
                tmr_q  <= '0;
              end else begin
                tmr_q <= tmr_q + 1'b1;
              end
            end
            default: st_q <= ST_IDLE;
          endcase
        end
      end
    end else begin : g_single
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          step_q <= 1'b0;
        end else begin
          step_q <= rise;
        end
      end
    end

    assign step[i] = step_q;
  end

  // Load wins outright; simultaneous inc and dec cancel.
  always_comb begin
    n_d   = n_q;
    sat_d = sat_q;
    if (step[2]) begin
      n_d   = sw_s2_q;
      sat_d = 1'b0;
    end else if (step[0] && !step[1]) begin
      if (n_q == 8'h7F) begin
        sat_d = 1'b1;
      end else begin
        n_d   = n_q + 8'h01;
        sat_d = 1'b0;
      end
    end else if (step[1] && !step[0]) begin
      if (n_q == 8'h80) begin
        sat_d = 1'b1;
      end else begin
        n_d   = n_q - 8'h01;
        sat_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q   <= 8'h00;
      sat_q <= 1'b0;
    end else begin
      n_q   <= n_d;
      sat_q <= sat_d;
    end
  end

  assign n   = n_q;
  assign sat = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_key_value_counter.sv
`default_nettype none
// tb_key_value_counter: directed self-checking bench with shortened debounce and repeat timing.
// Revision 1.0 - initial release.
module tb_key_value_counter;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_inc = 1'b0;
  logic       btn_dec = 1'b0;
  logic       btn_load = 1'b0;
  logic [7:0] sw = 8'h00;
  logic [7:0] n;
  logic       sat;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  key_value_counter #(
    .DB_CYCLES    (DB),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_inc (btn_inc),
    .btn_dec (btn_dec),
    .btn_load(btn_load),
    .sw      (sw),
    .n       (n),
    .sat     (sat)
  );

  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Steps seen on n, j edges after the first sampled-high edge of a held inc/dec.
  function automatic int steps(input int j);
    int s;
    s = 0;
    if (j >= 7) s = 1;
    if (j >= 7 + RD) s = s + 1 + (j - 7 - RD) / RP;
    return s;
  endfunction

  task automatic press(input bit inc, input bit dec, input bit load, input int hold);
    btn_inc  = inc;
    btn_dec  = dec;
    btn_load = load;
    tick(hold);
    btn_inc  = 1'b0;
    btn_dec  = 1'b0;
    btn_load = 1'b0;
    tick(20);
  endtask

  task automatic test_reset;
    #2;
    vecs++;
    if (n !== 8'h00 || sat !== 1'b0) begin
      errs++;
      $display("FAIL reset_async n=%h sat=%b expected n=00 sat=0", n, sat);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(5);
    vecs++;
    if (n !== 8'h00 || sat !== 1'b0) begin
      errs++;
      $display("FAIL reset_release n=%h sat=%b expected n=00 sat=0", n, sat);
    end
  endtask

  task automatic test_single_press;
    logic [7:0] exp;
    btn_inc = 1'b1;
    for (int j = 0; j < 10; j++) begin
      tick(1);
      exp = (j >= 7) ? 8'h01 : 8'h00;
      vecs++;
      if (n !== exp) begin
        errs++;
        $display("FAIL single_press j=%0d n=%h expected %h", j, n, exp);
      end
    end
    btn_inc = 1'b0;
    tick(30);
    vecs++;
    if (n !== 8'h01 || sat !== 1'b0) begin
      errs++;
      $display("FAIL single_press_settle n=%h sat=%b expected n=01 sat=0", n, sat);
    end
  endtask

  task automatic test_glitch;
    btn_inc = 1'b1;
    tick(3);
    btn_inc = 1'b0;
    tick(20);
    vecs++;
    if (n !== 8'h01 || sat !== 1'b0) begin
      errs++;
      $display("FAIL glitch n=%h sat=%b expected n=01 sat=0", n, sat);
    end
  endtask

  task automatic test_sat_high;
    int         e;
    logic [7:0] exp_n;
    logic       exp_s;
    sw = 8'h7E;
    press(1'b0, 1'b0, 1'b1, 10);
    vecs++;
    if (n !== 8'h7E || sat !== 1'b0) begin
      errs++;
      $display("FAIL sat_high_load n=%h sat=%b expected n=7e sat=0", n, sat);
    end
    btn_inc = 1'b1;
    for (int j = 0; j < 70; j++) begin
      tick(1);
      e     = 'h7E + steps((j < 66) ? j : 66);
      exp_s = (e > 'h7F);
      if (e > 'h7F) e = 'h7F;
      exp_n = 8'(e);
      vecs++;
      if (n !== exp_n || sat !== exp_s) begin
        errs++;
        $display("FAIL sat_high j=%0d n=%h sat=%b expected n=%h sat=%b", j, n, sat, exp_n, exp_s);
      end
      if (j == 59) btn_inc = 1'b0;
    end
    tick(10);
  endtask

  task automatic test_repeat_dec;
    logic [7:0] exp_n;
    sw = 8'h10;
    press(1'b0, 1'b0, 1'b1, 10);
    btn_dec = 1'b1;
    for (int j = 0; j < 55; j++) begin
      tick(1);
      exp_n = 8'h10 - 8'(steps((j < 46) ? j : 46));
      vecs++;
      if (n !== exp_n || sat !== 1'b0) begin
        errs++;
        $display("FAIL repeat_dec j=%0d n=%h sat=%b expected n=%h sat=0", j, n, sat, exp_n);
      end
      if (j == 39) btn_dec = 1'b0;
    end
    tick(10);
  endtask

  task automatic test_sat_low;
    sw = 8'h81;
    press(1'b0, 1'b0, 1'b1, 10);
    vecs++;
    if (n !== 8'h81 || sat !== 1'b0) begin
      errs++;
      $display("FAIL sat_low_load n=%h sat=%b expected n=81 sat=0", n, sat);
    end
    press(1'b0, 1'b1, 1'b0, 10);
    vecs++;
    if (n !== 8'h80 || sat !== 1'b0) begin
      errs++;
      $display("FAIL sat_low_dec1 n=%h sat=%b expected n=80 sat=0", n, sat);
    end
    press(1'b0, 1'b1, 1'b0, 10);
    vecs++;
    if (n !== 8'h80 || sat !== 1'b1) begin
      errs++;
      $display("FAIL sat_low_dec2 n=%h sat=%b expected n=80 sat=1", n, sat);
    end
    press(1'b1, 1'b0, 1'b0, 10);
    vecs++;
    if (n !== 8'h81 || sat !== 1'b0) begin
      errs++;
      $display("FAIL sat_low_inc n=%h sat=%b expected n=81 sat=0", n, sat);
    end
  endtask

  task automatic test_simultaneous;
    press(1'b1, 1'b1, 1'b0, 10);
    vecs++;
    if (n !== 8'h81 || sat !== 1'b0) begin
      errs++;
      $display("FAIL inc_dec_cancel n=%h sat=%b expected n=81 sat=0", n, sat);
    end
    sw = 8'hF6;
    press(1'b1, 1'b0, 1'b1, 10);
    vecs++;
    if (n !== 8'hF6 || sat !== 1'b0) begin
      errs++;
      $display("FAIL load_over_inc n=%h sat=%b expected n=f6 sat=0", n, sat);
    end
  endtask

  task automatic test_reset_in_repeat;
    btn_dec = 1'b1;
    tick(30);
    vecs++;
    if (n !== 8'hF4) begin
      errs++;
      $display("FAIL pre_reset_repeat n=%h expected f4", n);
    end
    #2;
    rst = 1'b1;
    #1;
    vecs++;
    if (n !== 8'h00 || sat !== 1'b0) begin
      errs++;
      $display("FAIL reset_mid_hold n=%h sat=%b expected n=00 sat=0", n, sat);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int j = 0; j < 40; j++) begin
      tick(1);
      vecs++;
      if (n !== 8'h00) begin
        errs++;
        $display("FAIL held_after_reset j=%0d n=%h expected 00", j, n);
      end
    end
    btn_dec = 1'b0;
    tick(20);
    vecs++;
    if (n !== 8'h00 || sat !== 1'b0) begin
      errs++;
      $display("FAIL release_after_reset n=%h sat=%b expected n=00 sat=0", n, sat);
    end
    press(1'b0, 1'b1, 1'b0, 10);
    vecs++;
    if (n !== 8'hFF || sat !== 1'b0) begin
      errs++;
      $display("FAIL repress_after_reset n=%h sat=%b expected n=ff sat=0", n, sat);
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_glitch();
    test_sat_high();
    test_repeat_dec();
    test_sat_low();
    test_simultaneous();
    test_reset_in_repeat();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire
